// File: rtl/e203_ifu_brpred_pkg.sv
// Shared types and constants for the IFU branch-prediction stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package e203_ifu_brpred_pkg;

    // Prediction-stage control state
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DEP = 2'd1,
        ST_RS1_RD   = 2'd2,
        ST_OUT_PEND = 2'd3
    } bpu_state_t;

    // Sequential PC increments for 32-bit and compressed instructions
    localparam int unsigned PC_INC32 = 4;
    localparam int unsigned PC_INC16 = 2;

    // Architectural register indices with special JALR handling
    localparam int unsigned RF_X0 = 0;
    localparam int unsigned RF_X1 = 1;

endpackage

// File: rtl/e203_ifu_brpred_jalrdep.sv
// JALR rs1 dependency check and regfile read sequencing for the prediction stage.
// Latency: rs1 value same cycle for x0/x1 without hazard; read-port data one cycle after ena.
// Backpressure: holds the captured rs1 value in OUT_PEND while the output register is busy.
module e203_ifu_brpred_jalrdep
    import e203_ifu_brpred_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               accept,
    input  logic               acc_jalr,
    input  logic [RFIDX_W-1:0] acc_rs1idx,
    input  logic [RFIDX_W-1:0] hold_rs1idx,
    input  logic               oitf_empty,
    input  logic               ir_empty,
    input  logic               ir_rdwen,
    input  logic [RFIDX_W-1:0] ir_rdidx,
    input  logic [XLEN-1:0]    rf2bpu_x1,
    input  logic [XLEN-1:0]    rf2bpu_rs1,
    input  logic               out_free,
    output bpu_state_t         state,
    output logic               rs1val_valid,
    output logic [XLEN-1:0]    rs1val,
    output logic               bpu2rf_rs1_ena,
    output logic [RFIDX_W-1:0] bpu2rf_rs1_idx
);

    bpu_state_t         state_q;
    bpu_state_t         state_d;
    logic [XLEN-1:0]    rs1_q;
    logic [RFIDX_W-1:0] idx;
    logic               is_x0;
    logic               is_x1;
    logic               ir_x1_hit;
    logic               dep;
    logic               rd_req;
    logic               val_vld;
    logic [XLEN-1:0]    val;

    // In IDLE the index comes straight from the accepting instruction, later from the holding copy
    assign idx       = (state_q == ST_IDLE) ? acc_rs1idx : hold_rs1idx;
    assign is_x0     = (idx == RFIDX_W'(RF_X0));
    assign is_x1     = (idx == RFIDX_W'(RF_X1));
    assign ir_x1_hit = !ir_empty & ir_rdwen & (ir_rdidx == RFIDX_W'(RF_X1));

    // x1 has a dedicated regfile tap, so only a real x1 writer in IR blocks it;
    // any other register shares the read port and waits for a quiet IR stage
    always_comb begin
        dep = 1'b0;
        if (is_x0) begin
            dep = 1'b0;
        end else if (is_x1) begin
            dep = !oitf_empty | ir_x1_hit;
        end else begin
            dep = !oitf_empty | !ir_empty;
        end
    end

    // Next-state and rs1 value selection; flush overrides everything
    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        val_vld = 1'b0;
        val     = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept && acc_jalr) begin
                    if (dep) begin
                        state_d = ST_WAIT_DEP;
                    end else if (is_x0) begin
                        val_vld = 1'b1;
                    end else if (is_x1) begin
                        val_vld = 1'b1;
                        val     = rf2bpu_x1;
                    end else begin
                        rd_req  = 1'b1;
                        state_d = ST_RS1_RD;
                    end
                end
            end
            ST_WAIT_DEP: begin
                if (!dep) begin
                    if (is_x0 || is_x1) begin
                        val = is_x1 ? rf2bpu_x1 : '0;
                        if (out_free) begin
                            val_vld = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_OUT_PEND;
                        end
                    end else begin
                        rd_req  = 1'b1;
                        state_d = ST_RS1_RD;
                    end
                end
            end
            ST_RS1_RD: begin
                val = rf2bpu_rs1;
                if (out_free) begin
                    val_vld = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT_PEND;
                end
            end
            ST_OUT_PEND: begin
                val = rs1_q;
                if (out_free) begin
                    val_vld = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            rd_req  = 1'b0;
            val_vld = 1'b0;
        end
    end

    // State register; rs1 value is parked when the output register cannot take it yet
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rs1_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d == ST_OUT_PEND) && (state_q != ST_OUT_PEND)) begin
                rs1_q <= val;
            end
        end
    end

    assign state          = state_q;
    assign rs1val_valid   = val_vld;
    assign rs1val         = val;
    assign bpu2rf_rs1_ena = rd_req & !rst;
    assign bpu2rf_rs1_idx = bpu2rf_rs1_ena ? idx : '0;

endmodule

// File: rtl/e203_ifu_brpred.sv
// Static branch predictor producing a registered next-PC for the PC generator.
// Latency: 1 cycle for non-JALR and hazard-free x0/x1 JALR; longer while a JALR waits on rs1.
// Backpressure: output held stable while o_valid & !o_ready; i_ready drops until the slot frees.
module e203_ifu_brpred
    import e203_ifu_brpred_pkg::*;
#(
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [PC_SIZE-1:0] i_pc,
    input  logic               i_rv32,
    input  logic               i_jal,
    input  logic               i_jalr,
    input  logic               i_bxx,
    input  logic [XLEN-1:0]    i_bjp_imm,
    input  logic [RFIDX_W-1:0] i_jalr_rs1idx,
    input  logic               oitf_empty,
    input  logic               ir_empty,
    input  logic               ir_rdwen,
    input  logic [RFIDX_W-1:0] ir_rdidx,
    input  logic [XLEN-1:0]    rf2bpu_x1,
    output logic               bpu2rf_rs1_ena,
    output logic [RFIDX_W-1:0] bpu2rf_rs1_idx,
    input  logic [XLEN-1:0]    rf2bpu_rs1,
    input  logic               flush,
    output logic               o_valid,
    input  logic               o_ready,
    output logic               o_prdt_taken,
    output logic [PC_SIZE-1:0] o_prdt_pc
);

    typedef struct packed {
        logic [PC_SIZE-1:0] pc;
        logic               rv32;
        logic               jal;
        logic               jalr;
        logic               bxx;
        logic [XLEN-1:0]    imm;
        logic [RFIDX_W-1:0] rs1idx;
    } hdr_t;

    bpu_state_t         state;
    hdr_t               in_hdr;
    hdr_t               hold_q;
    hdr_t               cur;
    logic               out_free;
    logic               accept;
    logic               load;
    logic               rs1val_valid;
    logic [XLEN-1:0]    rs1val;
    logic [PC_SIZE-1:0] inc;
    logic [PC_SIZE-1:0] imm_pc;
    logic [PC_SIZE-1:0] seq_pc;
    logic [PC_SIZE-1:0] tgt_pc;
    logic [PC_SIZE-1:0] jalr_pc;
    logic               prdt_taken;
    logic [PC_SIZE-1:0] prdt_pc;

    assign out_free = !o_valid | o_ready;
    assign i_ready  = (state == ST_IDLE) & out_free & !flush;
    assign accept   = i_valid & i_ready;

    assign in_hdr = '{pc: i_pc, rv32: i_rv32, jal: i_jal, jalr: i_jalr, bxx: i_bxx,
                      imm: i_bjp_imm, rs1idx: i_jalr_rs1idx};

    // Keep the accepted instruction for JALRs that outlive the accept cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (accept) begin
            hold_q <= in_hdr;
        end
    end

    // Only IDLE can compute from live inputs; other states finish a held JALR
    assign cur = (state == ST_IDLE) ? in_hdr : hold_q;

    e203_ifu_brpred_jalrdep #(
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W)
    ) u_jalrdep (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .accept         (accept),
        .acc_jalr       (i_jalr),
        .acc_rs1idx     (i_jalr_rs1idx),
        .hold_rs1idx    (hold_q.rs1idx),
        .oitf_empty     (oitf_empty),
        .ir_empty       (ir_empty),
        .ir_rdwen       (ir_rdwen),
        .ir_rdidx       (ir_rdidx),
        .rf2bpu_x1      (rf2bpu_x1),
        .rf2bpu_rs1     (rf2bpu_rs1),
        .out_free       (out_free),
        .state          (state),
        .rs1val_valid   (rs1val_valid),
        .rs1val         (rs1val),
        .bpu2rf_rs1_ena (bpu2rf_rs1_ena),
        .bpu2rf_rs1_idx (bpu2rf_rs1_idx)
    );

    // Adders wrap modulo 2^PC_SIZE by truncation
    assign inc     = cur.rv32 ? PC_SIZE'(PC_INC32) : PC_SIZE'(PC_INC16);
    assign imm_pc  = cur.imm[PC_SIZE-1:0];
    assign seq_pc  = cur.pc + inc;
    assign tgt_pc  = cur.pc + imm_pc;
    assign jalr_pc = rs1val[PC_SIZE-1:0] + imm_pc;

    // Static rules: jumps taken, conditional branches backward-taken/forward-not-taken
    always_comb begin
        prdt_taken = 1'b0;
        prdt_pc    = seq_pc;
        if (cur.jal) begin
            prdt_taken = 1'b1;
            prdt_pc    = tgt_pc;
        end else if (cur.jalr) begin
            prdt_taken = 1'b1;
            prdt_pc    = jalr_pc;
        end else if (cur.bxx) begin
            prdt_taken = cur.imm[XLEN-1];
            prdt_pc    = cur.imm[XLEN-1] ? tgt_pc : seq_pc;
        end
    end

    assign load = !flush & ((accept & !i_jalr) | rs1val_valid);

    // Output slot: reload wins over the consume-clear so back-to-back has no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid      <= 1'b0;
            o_prdt_taken <= 1'b0;
            o_prdt_pc    <= '0;
        end else if (flush) begin
            o_valid <= 1'b0;
        end else if (load) begin
            o_valid      <= 1'b1;
            o_prdt_taken <= prdt_taken;
            o_prdt_pc    <= prdt_pc;
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_e203_ifu_brpred.sv
module tb_e203_ifu_brpred;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_pc;
    logic        i_rv32;
    logic        i_jal;
    logic        i_jalr;
    logic        i_bxx;
    logic [31:0] i_bjp_imm;
    logic [4:0]  i_jalr_rs1idx;
    logic        oitf_empty;
    logic        ir_empty;
    logic        ir_rdwen;
    logic [4:0]  ir_rdidx;
    logic [31:0] rf2bpu_x1;
    logic        bpu2rf_rs1_ena;
    logic [4:0]  bpu2rf_rs1_idx;
    logic [31:0] rf2bpu_rs1;
    logic        flush;
    logic        o_valid;
    logic        o_ready;
    logic        o_prdt_taken;
    logic [31:0] o_prdt_pc;

    int total = 0;
    int bad   = 0;
    int ena_cnt = 0;
    int ena_base;

    always #5 clk = ~clk;

    e203_ifu_brpred dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .i_ready        (i_ready),
        .i_pc           (i_pc),
        .i_rv32         (i_rv32),
        .i_jal          (i_jal),
        .i_jalr         (i_jalr),
        .i_bxx          (i_bxx),
        .i_bjp_imm      (i_bjp_imm),
        .i_jalr_rs1idx  (i_jalr_rs1idx),
        .oitf_empty     (oitf_empty),
        .ir_empty       (ir_empty),
        .ir_rdwen       (ir_rdwen),
        .ir_rdidx       (ir_rdidx),
        .rf2bpu_x1      (rf2bpu_x1),
        .bpu2rf_rs1_ena (bpu2rf_rs1_ena),
        .bpu2rf_rs1_idx (bpu2rf_rs1_idx),
        .rf2bpu_rs1     (rf2bpu_rs1),
        .flush          (flush),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_prdt_taken   (o_prdt_taken),
        .o_prdt_pc      (o_prdt_pc)
    );

    always @(posedge clk) begin
        if (bpu2rf_rs1_ena) ena_cnt <= ena_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_valid = 1'b0; i_jal = 1'b0; i_jalr = 1'b0; i_bxx = 1'b0;
    endtask

    task automatic present(input logic [31:0] pc, input logic rv32, input logic jal,
                           input logic jalr, input logic bxx, input logic [31:0] imm,
                           input logic [4:0] rs1);
        i_valid = 1'b1; i_pc = pc; i_rv32 = rv32; i_jal = jal; i_jalr = jalr;
        i_bxx = bxx; i_bjp_imm = imm; i_jalr_rs1idx = rs1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; o_ready = 1'b1;
        idle_in();
        i_pc = '0; i_rv32 = 1'b1; i_bjp_imm = '0; i_jalr_rs1idx = '0;
        oitf_empty = 1'b1; ir_empty = 1'b1; ir_rdwen = 1'b0; ir_rdidx = '0;
        rf2bpu_x1 = 32'h0; rf2bpu_rs1 = 32'hDEAD_BEEF;
        tick(); tick();
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_taken", 32'(o_prdt_taken), 0);
        chk("rst_pc", o_prdt_pc, 0);
        chk("rst_ena", 32'(bpu2rf_rs1_ena), 0);
        chk("rst_idx", 32'(bpu2rf_rs1_idx), 0);
        rst = 1'b0;
        #1;
        chk("idle_i_ready", 32'(i_ready), 1);

        // jal, latency 1
        tick();
        present(32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 5'd0);
        #1 chk("jal_i_ready", 32'(i_ready), 1);
        tick();
        idle_in();
        #1;
        chk("jal_o_valid", 32'(o_valid), 1);
        chk("jal_taken", 32'(o_prdt_taken), 1);
        chk("jal_pc", o_prdt_pc, 32'h8000_0100);
        chk("jal_i_ready_after", 32'(i_ready), 1);
        tick();
        chk("jal_consumed", 32'(o_valid), 0);

        // bxx backward taken, then forward not taken 16-bit back to back
        present(32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 5'd0);
        tick();
        present(32'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 5'd0);
        #1;
        chk("bxx_bwd_taken", 32'(o_prdt_taken), 1);
        chk("bxx_bwd_pc", o_prdt_pc, 32'h0FF8);
        tick();
        idle_in();
        #1;
        chk("bxx_fwd_valid", 32'(o_valid), 1);
        chk("bxx_fwd_taken", 32'(o_prdt_taken), 0);
        chk("bxx_fwd_pc", o_prdt_pc, 32'h1002);
        tick();

        // jalr x5 waiting on OITF, then regfile read
        ena_base = ena_cnt;
        oitf_empty = 1'b0;
        present(32'h500, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 5'd5);
        #1;
        chk("jalr5_accept_ena", 32'(bpu2rf_rs1_ena), 0);
        tick();
        idle_in();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("jalr5_wait_i_ready", 32'(i_ready), 0);
            chk("jalr5_wait_ena", 32'(bpu2rf_rs1_ena), 0);
            tick();
        end
        oitf_empty = 1'b1;
        #1;
        chk("jalr5_ena", 32'(bpu2rf_rs1_ena), 1);
        chk("jalr5_idx", 32'(bpu2rf_rs1_idx), 5);
        chk("jalr5_rd_i_ready", 32'(i_ready), 0);
        tick();
        rf2bpu_rs1 = 32'h2000;
        #1;
        chk("jalr5_data_ena", 32'(bpu2rf_rs1_ena), 0);
        chk("jalr5_data_o_valid", 32'(o_valid), 0);
        chk("jalr5_data_i_ready", 32'(i_ready), 0);
        tick();
        rf2bpu_rs1 = 32'hDEAD_BEEF;
        #1;
        chk("jalr5_o_valid", 32'(o_valid), 1);
        chk("jalr5_taken", 32'(o_prdt_taken), 1);
        chk("jalr5_pc", o_prdt_pc, 32'h2004);
        chk("jalr5_ena_once", 32'(ena_cnt - ena_base), 1);
        tick();

        // jalr x1 blocked by IR writer of x1
        ena_base = ena_cnt;
        ir_empty = 1'b0; ir_rdwen = 1'b1; ir_rdidx = 5'd1; rf2bpu_x1 = 32'h3000;
        present(32'h600, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 5'd1);
        tick();
        idle_in();
        #1;
        chk("jalr1_wait_o_valid", 32'(o_valid), 0);
        chk("jalr1_wait_i_ready", 32'(i_ready), 0);
        tick();
        ir_empty = 1'b1;
        #1 chk("jalr1_no_ena", 32'(bpu2rf_rs1_ena), 0);
        tick();
        chk("jalr1_o_valid", 32'(o_valid), 1);
        chk("jalr1_pc", o_prdt_pc, 32'h2FFC);
        chk("jalr1_ena_none", 32'(ena_cnt - ena_base), 0);
        tick();

        // jalr x1 with IR writing a different register: no hazard
        ir_empty = 1'b0; ir_rdidx = 5'd3;
        present(32'h700, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 5'd1);
        tick();
        idle_in();
        #1;
        chk("jalr1_nohz_valid", 32'(o_valid), 1);
        chk("jalr1_nohz_pc", o_prdt_pc, 32'h3008);
        // jalr x0 ignores busy IR and OITF
        oitf_empty = 1'b0;
        present(32'h800, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 5'd0);
        tick();
        idle_in();
        #1 chk("jalr0_pc", o_prdt_pc, 32'h40);
        oitf_empty = 1'b1; ir_empty = 1'b1; ir_rdwen = 1'b0; ir_rdidx = '0;
        tick();

        // backpressure then back-to-back
        o_ready = 1'b0;
        present(32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 5'd0);
        tick();
        present(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_o_valid", 32'(o_valid), 1);
            chk("bp_taken", 32'(o_prdt_taken), 1);
            chk("bp_pc", o_prdt_pc, 32'h120);
            chk("bp_i_ready", 32'(i_ready), 0);
            tick();
        end
        o_ready = 1'b1;
        #1 chk("bp_release_i_ready", 32'(i_ready), 1);
        tick();
        idle_in();
        #1;
        chk("b2b_o_valid", 32'(o_valid), 1);
        chk("b2b_taken", 32'(o_prdt_taken), 0);
        chk("b2b_pc", o_prdt_pc, 32'h204);
        tick();
        chk("b2b_consumed", 32'(o_valid), 0);

        // flush while waiting on a dependency
        ena_base = ena_cnt;
        oitf_empty = 1'b0;
        present(32'h900, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 5'd5);
        tick();
        idle_in();
        flush = 1'b1;
        #1;
        chk("flush_i_ready", 32'(i_ready), 0);
        tick();
        flush = 1'b0; oitf_empty = 1'b1;
        #1;
        chk("flush_idle", 32'(i_ready), 1);
        chk("flush_no_ena", 32'(bpu2rf_rs1_ena), 0);
        chk("flush_o_valid", 32'(o_valid), 0);
        tick();
        chk("flush_no_stale", 32'(o_valid), 0);
        chk("flush_ena_none", 32'(ena_cnt - ena_base), 0);

        // reset while in the regfile read state
        rf2bpu_rs1 = 32'h2000;
        present(32'hA00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, 5'd5);
        #1;
        chk("rstrd_ena", 32'(bpu2rf_rs1_ena), 1);
        tick();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rstrd_o_valid", 32'(o_valid), 0);
        chk("rstrd_pc", o_prdt_pc, 0);
        chk("rstrd_taken", 32'(o_prdt_taken), 0);
        chk("rstrd_i_ready", 32'(i_ready), 1);
        tick();
        chk("rstrd_no_stale", 32'(o_valid), 0);

        // sequential PC wraps
        present(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        tick();
        idle_in();
        #1;
        chk("wrap_valid", 32'(o_valid), 1);
        chk("wrap_taken", 32'(o_prdt_taken), 0);
        chk("wrap_pc", o_prdt_pc, 32'h0000_0002);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
